// File: rtl/mux_scan_serializer_pkg.sv
// rtl/mux_scan_serializer_pkg.sv - shared types and constants for the mux scan serializer
package mux_scan_serializer_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam int WORD_W = 16;
   localparam int SEL_W  = 4;

   // Start and terminal select index for the chosen bit order.
   function automatic logic [SEL_W-1:0] sel_first(input bit msb_first);
      return msb_first ? SEL_W'(WORD_W - 1) : '0;
   endfunction

   function automatic logic [SEL_W-1:0] sel_last(input bit msb_first);
      return msb_first ? '0 : SEL_W'(WORD_W - 1);
   endfunction

endpackage

// File: rtl/mux_scan_serializer_mux16to1.sv
// rtl/mux_scan_serializer_mux16to1.sv - 16:1 bit multiplexer driven by the serializer select
module mux16to1
   import mux_scan_serializer_pkg::*;
(
   input  logic [WORD_W-1:0] in,
   input  logic [SEL_W-1:0]  sel,
   output logic              y
);

   assign y = in[sel];

endmodule

// File: rtl/mux_scan_serializer.sv
// rtl/mux_scan_serializer.sv - parallel-to-serial stage walking a 16:1 mux select
// A word is held in data_q while sel_q steps one index per BIT_CYCLES accepted beats.
module mux_scan_serializer
   import mux_scan_serializer_pkg::*;
#(
   parameter bit MSB_FIRST  = 1'b0,
   parameter int BIT_CYCLES = 1
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic [WORD_W-1:0] load_data,
   input  logic              load_valid,
   output logic              load_ready,
   output logic              ser_out,
   output logic              ser_valid,
   input  logic              ser_ready,
   output logic              ser_last,
   output logic              busy
);

   localparam int DIV_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BIT_CYCLES - 1);
   localparam logic [SEL_W-1:0] SEL_FIRST = sel_first(MSB_FIRST);
   localparam logic [SEL_W-1:0] SEL_LAST  = sel_last(MSB_FIRST);

   state_t             state, next_state;
   logic [WORD_W-1:0]  data_q;
   logic [SEL_W-1:0]   sel_q;
   logic [DIV_W-1:0]   div_q;
   logic               accept;
   logic               bit_done;
   logic               word_done;

   assign accept    = (state == SHIFT) && ser_ready;
   assign bit_done  = accept && (div_q == DIV_LAST);
   assign word_done = bit_done && (sel_q == SEL_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (load_valid) next_state = SHIFT;
         SHIFT:   if (word_done)  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      load_ready = (state == IDLE);
      ser_valid  = (state == SHIFT);
      busy       = (state == SHIFT);
      ser_last   = (state == SHIFT) && (sel_q == SEL_LAST);
   end

   // Terminal index returns sel_q to the start so the next word begins cleanly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
         sel_q  <= '0;
         div_q  <= '0;
      end else if (state == IDLE) begin
         if (load_valid) begin
            data_q <= load_data;
            sel_q  <= SEL_FIRST;
            div_q  <= '0;
         end
      end else if (accept) begin
         if (bit_done) begin
            div_q <= '0;
            if (sel_q == SEL_LAST) sel_q <= SEL_FIRST;
            else if (MSB_FIRST)    sel_q <= sel_q - SEL_W'(1);
            else                   sel_q <= sel_q + SEL_W'(1);
         end else begin
            div_q <= div_q + DIV_W'(1);
         end
      end
   end

   mux16to1 u_mux (
      .in  (data_q),
      .sel (sel_q),
      .y   (ser_out)
   );

endmodule

// File: tb/tb_mux_scan_serializer.sv
// tb/tb_mux_scan_serializer.sv - self-checking bench for mux_scan_serializer
// Three instances: LSB-first x1, MSB-first x1, LSB-first x3 cycles per bit.
module tb_mux_scan_serializer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] load_data = '0;
   logic [2:0]  load_valid = '0;
   logic        ser_ready = 1'b1;
   logic [2:0]  load_ready, ser_out, ser_valid, ser_last, busy;
   logic [3:0]  sel_q [3];

   int n_checks = 0;
   int n_fail   = 0;

   localparam int P_MSB [3] = '{0, 1, 0};
   localparam int P_BC  [3] = '{1, 1, 3};

   always #5 clk = ~clk;

   mux_scan_serializer #(.MSB_FIRST(1'b0), .BIT_CYCLES(1)) dut0 (
      .clk(clk), .rst(rst), .load_data(load_data), .load_valid(load_valid[0]),
      .load_ready(load_ready[0]), .ser_out(ser_out[0]), .ser_valid(ser_valid[0]),
      .ser_ready(ser_ready), .ser_last(ser_last[0]), .busy(busy[0]));
   mux_scan_serializer #(.MSB_FIRST(1'b1), .BIT_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst), .load_data(load_data), .load_valid(load_valid[1]),
      .load_ready(load_ready[1]), .ser_out(ser_out[1]), .ser_valid(ser_valid[1]),
      .ser_ready(ser_ready), .ser_last(ser_last[1]), .busy(busy[1]));
   mux_scan_serializer #(.MSB_FIRST(1'b0), .BIT_CYCLES(3)) dut2 (
      .clk(clk), .rst(rst), .load_data(load_data), .load_valid(load_valid[2]),
      .load_ready(load_ready[2]), .ser_out(ser_out[2]), .ser_valid(ser_valid[2]),
      .ser_ready(ser_ready), .ser_last(ser_last[2]), .busy(busy[2]));

   assign sel_q[0] = dut0.sel_q;
   assign sel_q[1] = dut1.sel_q;
   assign sel_q[2] = dut2.sel_q;

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endfunction

   // Model: a word in flight is a beat count 0..16*BC-1; the bit index is beat/BC.
   bit          m_busy [3];
   logic [15:0] m_word [3];
   int          m_beat [3];

   always @(posedge clk or posedge rst) begin
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            m_busy[i] = 1'b0; m_word[i] = '0; m_beat[i] = 0;
         end else if (m_busy[i]) begin
            if (ser_ready) begin
               m_beat[i] = m_beat[i] + 1;
               if (m_beat[i] == 16 * P_BC[i]) begin
                  m_busy[i] = 1'b0; m_beat[i] = 0;
               end
            end
         end else if (load_valid[i]) begin
            m_busy[i] = 1'b1; m_word[i] = load_data; m_beat[i] = 0;
         end
      end
   end

   always @(posedge clk) begin
      #2;
      for (int i = 0; i < 3; i++) begin
         int idx, sel;
         idx = m_busy[i] ? m_beat[i] / P_BC[i] : 0;
         sel = P_MSB[i] ? 15 - idx : idx;
         chk($sformatf("m%0d_load_ready", i), load_ready[i], !m_busy[i]);
         chk($sformatf("m%0d_ser_valid", i), ser_valid[i], m_busy[i]);
         chk($sformatf("m%0d_busy", i), busy[i], m_busy[i]);
         chk($sformatf("m%0d_ser_last", i), ser_last[i], m_busy[i] && idx == 15);
         chk($sformatf("m%0d_ser_out", i), ser_out[i], m_word[i][sel]);
         if (m_busy[i]) chk($sformatf("m%0d_sel", i), sel_q[i], sel);
      end
   end

   task automatic start(input int i, input logic [15:0] d);
      @(negedge clk);
      load_data = d;
      load_valid[i] = 1'b1;
      @(negedge clk);
      load_valid[i] = 1'b0;
   endtask

   // Called at the negedge after capture; returns at the negedge where ser_valid has dropped.
   task automatic collect(input int i, input int stall_at, input int stop_at,
                          output logic [47:0] bits, output int nb, output int nl,
                          output int first_last);
      int c = 0;
      bit stalled = 0;
      bits = '0; nb = 0; nl = 0; first_last = -1;
      while (ser_valid[i] && c < 300 && nb != stop_at) begin
         if (nb == stall_at && !stalled) begin
            stalled = 1;
            ser_ready = 1'b0;
            repeat (5) begin
               @(negedge clk);
               chk("bp_out_held", ser_out[i], 1'b1);
               chk("bp_sel_frozen", sel_q[i], 4'd4);
            end
            ser_ready = 1'b1;
         end
         if (ser_ready) begin
            bits[nb] = ser_out[i];
            if (ser_last[i]) begin
               if (first_last < 0) first_last = nb;
               nl++;
            end
            nb++;
         end
         @(negedge clk);
         c++;
      end
      if (c >= 300) chk("collect_timeout", 1, 0);
   endtask

   logic [47:0] bits;
   int nb, nl, fl;

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_load_ready", load_ready, 3'b111);
      chk("rst_ser_valid", ser_valid, 3'b000);
      chk("rst_busy", busy, 3'b000);
      chk("rst_ser_out", ser_out, 3'b000);
      chk("rst_ser_last", ser_last, 3'b000);

      // LSB first, one cycle per bit
      start(0, 16'hA5C3);
      collect(0, -1, -1, bits, nb, nl, fl);
      chk("t2_bits", bits[15:0], 16'b1010_0101_1100_0011);
      chk("t2_beats", nb, 16);
      chk("t2_last_cnt", nl, 1);
      chk("t2_last_pos", fl, 15);
      chk("t2_ready_17th", load_ready[0], 1'b1);

      // MSB first: first collected bit is bit 15
      start(1, 16'h8001);
      collect(1, -1, -1, bits, nb, nl, fl);
      chk("t3_first", bits[0], 1'b1);
      chk("t3_middle", bits[14:1], 14'h0);
      chk("t3_lastbit", bits[15], 1'b1);
      chk("t3_last_cnt", nl, 1);

      // Backpressure at bit 4
      start(0, 16'h00F0);
      collect(0, 4, -1, bits, nb, nl, fl);
      chk("t4_bits", bits[15:0], 16'h00F0);
      chk("t4_beats", nb, 16);

      // Three cycles per bit
      start(2, 16'h0003);
      collect(2, -1, -1, bits, nb, nl, fl);
      chk("t5_bits", bits, 48'h0000_0000_003F);
      chk("t5_beats", nb, 48);
      chk("t5_last_cnt", nl, 3);
      chk("t5_last_pos", fl, 45);

      // load_valid held with new data during SHIFT
      start(0, 16'h1234);
      load_valid[0] = 1'b1;
      load_data = 16'hBEEF;
      collect(0, -1, -1, bits, nb, nl, fl);
      chk("t6_first_word", bits[15:0], 16'h1234);
      chk("t6_idle_gap", load_ready[0], 1'b1);
      @(negedge clk);
      load_valid[0] = 1'b0;
      chk("t6_second_started", ser_valid[0], 1'b1);
      collect(0, -1, -1, bits, nb, nl, fl);
      chk("t6_second_word", bits[15:0], 16'hBEEF);

      // Asynchronous reset mid-word at sel 7
      start(0, 16'hFFFF);
      collect(0, -1, 7, bits, nb, nl, fl);
      chk("t1_sel_before", sel_q[0], 4'd7);
      #1 rst = 1'b1;
      #1;
      chk("t1_ser_valid", ser_valid[0], 1'b0);
      chk("t1_load_ready", load_ready[0], 1'b1);
      chk("t1_busy", busy[0], 1'b0);
      chk("t1_ser_out", ser_out[0], 1'b0);
      @(negedge clk);
      rst = 1'b0;
      start(0, 16'h0001);
      collect(0, -1, -1, bits, nb, nl, fl);
      chk("t1_restart", bits[15:0], 16'h0001);
      chk("t1_restart_beats", nb, 16);

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
